// File: rtl/commutator_delay_pkg.sv
// -----------------------------------------------------------------------------
// commutator_delay_pkg
// Shared constants for the streaming radix-2 FFT datapath.
//   FFT_W           default data width per lane
//   FFT_LOG2N       log2 of the FFT size
//   STAGE_DEPTH_LOG commutator DEPTH_LOG for each stage, first stage first
//                   (log2N-1 down to 0)
//   stage_depth_log helper returning the DEPTH_LOG for a given stage index
// -----------------------------------------------------------------------------
package commutator_delay_pkg;

  localparam int FFT_W     = 8;
  localparam int FFT_LOG2N = 4;

  // Stage s delays by 2**(FFT_LOG2N-1-s) samples.
  localparam int STAGE_DEPTH_LOG [FFT_LOG2N] = '{3, 2, 1, 0};

  // Legal DEPTH_LOG values for the commutator are 0..10.
  localparam int DEPTH_LOG_MAX = 10;

  function automatic int stage_depth_log(input int stage);
    return FFT_LOG2N - 1 - stage;
  endfunction

endpackage

// File: rtl/commutator_delay_delay_line.sv
// -----------------------------------------------------------------------------
// delay_line
// Clock-enabled shift register of DEPTH entries, W bits each. Also used for
// the lane-y delay after cross_switch.
//   clk   in  1  clock, posedge
//   rst   in  1  synchronous reset, active-high; clears every entry
//   ce    in  1  clock enable; ce=0 freezes every entry
//   din   in  W  data shifted in on each enabled edge
//   dout  out W  oldest entry (din from DEPTH enabled edges ago)
// -----------------------------------------------------------------------------
module delay_line
  import commutator_delay_pkg::*;
#(
  parameter int W     = FFT_W + 1,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] line_q [DEPTH];
  logic [W-1:0] line_d [DEPTH];

  always_comb begin
    line_d = line_q;
    if (ce) begin
      line_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        line_d[i] = line_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q <= line_d;
    end
  end

  assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/commutator_delay.sv
// -----------------------------------------------------------------------------
// commutator_delay
// Input half of a radix-2 delay-commutator. Lane a is delayed by D=2**DEPTH_LOG
// enabled cycles plus an output register, lane b passes through one register,
// and a straight control is produced for cross_switch: 1 for D valid lane-b
// samples, 0 for the next D, repeating.
//   CLK        in   1      clock, posedge
//   RST        in   1      synchronous reset, active-high (beats ce and sclr)
//   ce         in   1      clock enable; ce=0 freezes every register
//   sclr       in   1      frame restart, honoured only when ce=1
//   valid_a/a  in   1/width lane a sample
//   valid_b/b  in   1/width lane b sample
//   valid_a_o/a_o out 1/width lane a, latency D+1 enabled cycles
//   valid_b_o/b_o out 1/width lane b, latency 1 enabled cycle
//   straight   out  1      switch control aligned with b_o (1 = a->x, b->y)
// DEPTH_LOG legal range is 0..10.
// -----------------------------------------------------------------------------
module commutator_delay
  import commutator_delay_pkg::*;
#(
  parameter int width     = FFT_W,
  parameter int DEPTH_LOG = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ce,
  input  logic             sclr,
  input  logic             valid_a,
  input  logic [width-1:0] a,
  input  logic             valid_b,
  input  logic [width-1:0] b,
  output logic             valid_a_o,
  output logic [width-1:0] a_o,
  output logic             valid_b_o,
  output logic [width-1:0] b_o,
  output logic             straight
);

  localparam int D  = 1 << DEPTH_LOG;
  localparam int CW = DEPTH_LOG + 1;
  localparam int LW = width + 1;

  // Lane a: valid bit travels with its data so gaps keep their slot.
  logic [LW-1:0] line_out;
  logic [LW-1:0] a_out_q, a_out_d;

  delay_line #(
    .W    (LW),
    .DEPTH(D)
  ) u_line_a (
    .clk (CLK),
    .rst (RST),
    .ce  (ce),
    .din ({valid_a, a}),
    .dout(line_out)
  );

  // Lane b register.
  logic [LW-1:0] b_out_q, b_out_d;

  // Phase counter: wraps 2D-1 -> 0 via natural CW-bit overflow.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          straight_q, straight_d;

  always_comb begin
    a_out_d    = a_out_q;
    b_out_d    = b_out_q;
    cnt_d      = cnt_q;
    straight_d = straight_q;
    if (ce) begin
      a_out_d = line_out;
      b_out_d = {valid_b, b};
      if (sclr) begin
        // Restart the frame; a valid sample on this cycle is phase 0.
        cnt_d      = valid_b ? CW'(1) : '0;
        straight_d = 1'b1;
      end else if (valid_b) begin
        // First half of each 2D period (MSB clear) is straight.
        straight_d = ~cnt_q[DEPTH_LOG];
        cnt_d      = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_out_q    <= '0;
      b_out_q    <= '0;
      cnt_q      <= '0;
      straight_q <= 1'b0;
    end else begin
      a_out_q    <= a_out_d;
      b_out_q    <= b_out_d;
      cnt_q      <= cnt_d;
      straight_q <= straight_d;
    end
  end

  assign valid_a_o = a_out_q[LW-1];
  assign a_o       = a_out_q[width-1:0];
  assign valid_b_o = b_out_q[LW-1];
  assign b_o       = b_out_q[width-1:0];
  assign straight  = straight_q;

endmodule

// File: tb/tb_commutator_delay.sv
// -----------------------------------------------------------------------------
// tb_commutator_delay
// Directed and random stimulus for commutator_delay (width=8, DEPTH_LOG=2).
// Expected lane data is pushed into queues as each sample is driven and popped
// as the matching output edge arrives.
// -----------------------------------------------------------------------------
module tb_commutator_delay;

  localparam int WIDTH     = 8;
  localparam int DEPTH_LOG = 2;
  localparam int D         = 1 << DEPTH_LOG;
  localparam int LW        = WIDTH + 1;

  // clock / reset block
  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ce = 1'b0;
  logic             sclr = 1'b0;
  logic             valid_a = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic             valid_b = 1'b0;
  logic [WIDTH-1:0] b = '0;
  logic             valid_a_o;
  logic [WIDTH-1:0] a_o;
  logic             valid_b_o;
  logic [WIDTH-1:0] b_o;
  logic             straight;

  always #5 CLK = ~CLK;

  commutator_delay #(
    .width    (WIDTH),
    .DEPTH_LOG(DEPTH_LOG)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ce       (ce),
    .sclr     (sclr),
    .valid_a  (valid_a),
    .a        (a),
    .valid_b  (valid_b),
    .b        (b),
    .valid_a_o(valid_a_o),
    .a_o      (a_o),
    .valid_b_o(valid_b_o),
    .b_o      (b_o),
    .straight (straight)
  );

  // scoreboard
  logic [LW-1:0] exp_q[$];     // lane a, pre-filled with D empty slots
  logic [LW-1:0] exp_b_q[$];   // lane b
  logic [LW-1:0] exp_a_cur;
  logic [LW-1:0] exp_b_cur;
  logic          exp_straight;
  int            phase_cnt;    // valid lane-b samples since reset/sclr
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_b_q.delete();
    for (int i = 0; i < D; i++) exp_q.push_back('0);
    exp_a_cur    = '0;
    exp_b_cur    = '0;
    exp_straight = 1'b0;
    phase_cnt    = 0;
  endtask

  // driver: apply one cycle of inputs, advance one edge, then check outputs
  task automatic step(input logic rst_i, input logic ce_i, input logic sclr_i,
                      input logic va, input logic [WIDTH-1:0] av,
                      input logic vb, input logic [WIDTH-1:0] bv);
    RST = rst_i; ce = ce_i; sclr = sclr_i;
    valid_a = va; a = av; valid_b = vb; b = bv;
    if (rst_i) begin
      model_reset();
    end else if (ce_i) begin
      exp_q.push_back({va, av});
      exp_b_q.push_back({vb, bv});
      if (sclr_i) begin
        exp_straight = 1'b1;
        phase_cnt    = vb ? 1 : 0;
      end else if (vb) begin
        exp_straight = ((phase_cnt / D) % 2) == 0;
        phase_cnt++;
      end
    end
    @(posedge CLK);
    #1;
    if (!rst_i && ce_i) begin
      exp_a_cur = exp_q.pop_front();
      exp_b_cur = exp_b_q.pop_front();
    end
    check("lane_a", {valid_a_o, a_o}, exp_a_cur);
    check("lane_b", {valid_b_o, b_o}, exp_b_cur);
    check("straight", {8'h00, straight}, {8'h00, exp_straight});
  endtask

  initial begin
    logic [WIDTH-1:0] av, bv;
    model_reset();

    // reset for two cycles, then idle with ce=1
    step(1, 0, 0, 0, 8'h00, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 8'h00, 0, 8'h00);

    // latency and straight pattern: 16 back-to-back samples
    for (int i = 1; i <= 16; i++)
      step(0, 1, 0, 1, WIDTH'(i), 1, WIDTH'(8'h10 + i));

    // gaps on lane b (cycles 3,7) and ce low (cycles 10-12)
    for (int i = 0; i < 16; i++) begin
      av = WIDTH'(8'h40 + i);
      bv = WIDTH'(8'h60 + i);
      if (i >= 10 && i <= 12)
        step(0, 0, 0, 1, 8'hEE, 1, 8'hEE);
      else
        step(0, 1, 0, 1, av, (i != 3 && i != 7), bv);
    end

    // sclr on the 6th sample
    for (int i = 1; i <= 12; i++)
      step(0, 1, (i == 6), 1, WIDTH'(8'h80 + i), 1, WIDTH'(8'hA0 + i));

    // reset on the 7th sample, then restart
    for (int i = 1; i <= 6; i++)
      step(0, 1, 0, 1, WIDTH'(8'hB0 + i), 1, WIDTH'(8'hC0 + i));
    step(1, 1, 0, 1, 8'hB7, 1, 8'hC7);
    for (int i = 1; i <= 10; i++)
      step(0, 1, 0, 1, WIDTH'(8'hD0 + i), 1, WIDTH'(8'hE0 + i));

    // random traffic
    for (int i = 0; i < 60; i++) begin
      step(0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
           $urandom_range(0, 1) == 1, WIDTH'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0, WIDTH'($urandom_range(0, 255)));
    end

    // drain
    for (int i = 0; i < D + 2; i++) step(0, 1, 0, 0, 8'h00, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
